hazard_tnew_tracker: RTL and testbench
======================================

HAZARD_TNEW_TRACKER -- requirements
Module: hazard_tnew_tracker

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning busy cycles after a mult-class instruction leaves E.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning busy cycles after a div-class instruction leaves E.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 d_a3  input  5  destination register of the D-stage instruction; 0 means no write.
REQ-006 d_tnew  input  2  cycles, counted from E entry, until that result is forwardable (0..2).
REQ-007 d_rs, d_rt  input  5 each  source register numbers of the D-stage instruction.
REQ-008 rs_tuse, rt_tuse  input  2 each  consumer Tuse for rs/rt; 3 = operand unused.
REQ-009 d_md_kind  input  2  0 none, 1 mult-class (mult/multu/madd), 2 div-class (div/divu), 3 reserved (treat as 0).
REQ-010 d_md_use  input  1  D instruction touches HI/LO (mfhi/mflo/mthi/mtlo/mult/div/madd).
REQ-011 stall  output  1  freeze PC/D, bubble into E.
REQ-012 e_a3, m_a3, w_a3  output  5 each  destination register held in E/M/W.
REQ-013 e_tnew, m_tnew  output  2 each  current remaining Tnew in E/M.
REQ-014 md_busy  output  1  HI/LO unit occupied.

Function
REQ-015 Each edge without stall: E <= {d_a3, d_tnew, d_md_kind}; M <= {e_a3, sat(e_tnew-1)}; W <= m_a3.
REQ-016 sat(x-1) SHALL saturate at 0 (tnew 0 stays 0; never wraps to 3).
REQ-017 On stall edge: E <= bubble {a3=0, tnew=0, md_kind=0}; M and W advance as in REQ-015.
REQ-018 rs hazard = d_rs!=0 && rs_tuse!=3 && ((d_rs==e_a3 && rs_tuse<e_tnew) || (d_rs==m_a3 && rs_tuse<m_tnew)); rt identical with rt fields.
REQ-019 W never causes a stall (its Tnew is 0 by construction).
REQ-020 Register 0 SHALL never match, even if a3=0 is presented with nonzero tnew.
REQ-021 stall = rs hazard | rt hazard | md hazard; purely combinational from current state and D inputs, no added latency.
REQ-022 Counter loads MULT_CYCLES or DIV_CYCLES on the edge that moves a mult/div-class instruction out of E, then decrements by 1 per edge down to 0.
REQ-023 md_busy = (counter!=0) | (E md_kind in {1,2}); md hazard = d_md_use & md_busy.
REQ-024 A new start cannot overlap a running count, because REQ-023 stalls it in D; a load SHALL override any decrement in the same cycle.

Reset
REQ-025 reset SHALL clear E, M and W to a3=0, tnew=0, md_kind=0, and the counter to 0; reset SHALL take priority over stall.
REQ-026 Right after reset: stall=0, md_busy=0, and all a3/tnew outputs = 0.
REQ-027 Reset asserted mid-count SHALL abort the count; the next cycle md_busy=0.

Configuration
REQ-028 Macro HAZARD_MD_STALL_EN defined: counter and md hazard present per REQ-022..024.
REQ-029 Macro undefined: counter logic is absent, md_busy ties to 0, d_md_kind and d_md_use are ignored, and the E md_kind field is dropped.

Structure
REQ-030 The shared header SHALL hold TUSE_NONE=3, the MD_NONE/MD_MULT/MD_DIV encodings, and default MULT_CYCLES/DIV_CYCLES.
REQ-031 One sub-module, md_busy_counter (load/decrement/busy), SHALL be instantiated only under HAZARD_MD_STALL_EN.

Verification
REQ-032 lw $8 (d_a3=8, d_tnew=2) then addu using rs=8 (rs_tuse=1) -> stall=1 for exactly 1 cycle, then 0 with m_a3=8 and m_tnew=1... but rs_tuse=1 >= m_tnew=1 -> no stall.
REQ-033 lw $8 then beq with rt=8 (rt_tuse=0) -> stall 2 cycles (E tnew 2, then M tnew 1), released when $8 is in W.
REQ-034 addu $0 (d_a3=0, d_tnew=1) then beq with rs=0 -> stall stays 0.
REQ-035 mult, then mflo immediately -> md_busy=1 for 1+5 cycles and stall=1 for 6 cycles; macro undefined -> stall=0 throughout.
REQ-036 div issued, reset pulsed 3 cycles after it leaves E -> next cycle counter=0, md_busy=0, all stage a3=0.
REQ-037 sw with rt=9 (rt_tuse=2) after addu $9 (d_tnew=1) -> stall=0; after lw $9 (d_tnew=2) -> stall=0 (2<2 false).

Source files
------------

// File: rtl/hazard_tnew_tracker_pkg.sv
// hazard_tnew_tracker_pkg: shared encodings, defaults and the Tuse/Tnew compare helper.
package hazard_tnew_tracker_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

    typedef enum logic [1:0] {
        MD_NONE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2,
        MD_RSVD = 2'd3
    } md_kind_t;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = a > b ? a : b;
        return m < 1 ? 1 : $clog2(m + 1);
    endfunction

    // A source stalls only if the producer's result arrives after the consumer needs it.
    function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                        input logic [4:0] ea, input logic [1:0] et,
                                        input logic [4:0] ma, input logic [1:0] mt);
        return src != 5'd0 && tuse != TUSE_NONE &&
               ((src == ea && tuse < et) || (src == ma && tuse < mt));
    endfunction

endpackage

// File: rtl/hazard_tnew_tracker_md_busy_counter.sv
// md_busy_counter: HI/LO occupancy counter, loaded as a mult/div leaves E, then counts down.
module md_busy_counter
    import hazard_tnew_tracker_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic     clk,
    input  logic     reset,
    input  md_kind_t kind,
    output logic     busy
);

    localparam int W = cnt_width(MULT_CYCLES, DIV_CYCLES);

    logic [W-1:0] count;
    logic         start;

    assign start = kind == MD_MULT || kind == MD_DIV;
    assign busy  = start || count != '0;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (start)
            count <= kind == MD_DIV ? W'(DIV_CYCLES) : W'(MULT_CYCLES);
        else if (count != '0)
            count <= count - W'(1);
    end

endmodule

// File: rtl/hazard_tnew_tracker.sv
// hazard_tnew_tracker: Tuse/Tnew stall logic for the E/M/W pipe.
// HAZARD_MD_STALL_EN adds the HI/LO busy counter and its stall term.
module hazard_tnew_tracker
    import hazard_tnew_tracker_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_a3,
    input  logic [1:0] d_tnew,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] rs_tuse,
    input  logic [1:0] rt_tuse,
    input  logic [1:0] d_md_kind,
    input  logic       d_md_use,
    output logic       stall,
    output logic [4:0] e_a3,
    output logic [4:0] m_a3,
    output logic [4:0] w_a3,
    output logic [1:0] e_tnew,
    output logic [1:0] m_tnew,
    output logic       md_busy
);

    logic md_hazard;

    assign stall = src_hazard(d_rs, rs_tuse, e_a3, e_tnew, m_a3, m_tnew) |
                   src_hazard(d_rt, rt_tuse, e_a3, e_tnew, m_a3, m_tnew) |
                   md_hazard;

    always_ff @(posedge clk) begin
        if (reset) begin
            e_a3   <= '0;
            e_tnew <= '0;
            m_a3   <= '0;
            m_tnew <= '0;
            w_a3   <= '0;
        end else begin
            e_a3   <= stall ? '0 : d_a3;
            e_tnew <= stall ? '0 : d_tnew;
            m_a3   <= e_a3;
            m_tnew <= e_tnew == 2'd0 ? 2'd0 : e_tnew - 2'd1;
            w_a3   <= m_a3;
        end
    end

`ifdef HAZARD_MD_STALL_EN
    md_kind_t e_md_kind;

    // Reserved kind is folded to none on capture so it never starts a count.
    always_ff @(posedge clk) begin
        if (reset)
            e_md_kind <= MD_NONE;
        else
            e_md_kind <= stall || d_md_kind == MD_RSVD ? MD_NONE : md_kind_t'(d_md_kind);
    end

    md_busy_counter #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_busy_counter (
        .clk  (clk),
        .reset(reset),
        .kind (e_md_kind),
        .busy (md_busy)
    );

    assign md_hazard = d_md_use & md_busy;
`else
    logic unused_md;

    assign unused_md = ^{d_md_kind, d_md_use, MULT_CYCLES[0], DIV_CYCLES[0]};
    assign md_busy   = 1'b0;
    assign md_hazard = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_tnew_tracker.sv
// tb_hazard_tnew_tracker: directed pipeline scenarios plus random stimulus against a
// timeline model (each instruction remembers when it entered E; HI/LO remembers when it frees).
module tb_hazard_tnew_tracker;

`ifdef HAZARD_MD_STALL_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_a3, d_rs, d_rt;
    logic [1:0] d_tnew, rs_tuse, rt_tuse, d_md_kind;
    logic       d_md_use;
    logic       stall, md_busy;
    logic [4:0] e_a3, m_a3, w_a3;
    logic [1:0] e_tnew, m_tnew;

    hazard_tnew_tracker #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .d_a3(d_a3), .d_tnew(d_tnew), .d_rs(d_rs), .d_rt(d_rt),
        .rs_tuse(rs_tuse), .rt_tuse(rt_tuse), .d_md_kind(d_md_kind), .d_md_use(d_md_use),
        .stall(stall), .e_a3(e_a3), .m_a3(m_a3), .w_a3(w_a3), .e_tnew(e_tnew),
        .m_tnew(m_tnew), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a3;
        int tnew;
        int te;
    } inst_t;

    inst_t q[$];
    int    now = 0;
    int    md_free = 0;
    int    checks = 0;
    int    errors = 0;
    bit    chk_en = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, now);
        end
    endtask

    function automatic int rem(input inst_t x);
        int r;
        r = x.tnew - (now - x.te);
        return r < 0 ? 0 : r;
    endfunction

    // Only E (age 0) and M (age 1) can still owe a result; W is always ready.
    function automatic bit hz(input int src, input int tuse);
        if (src == 0 || tuse == 3)
            return 1'b0;
        foreach (q[i])
            if (now - q[i].te <= 1 && q[i].a3 == src && tuse < rem(q[i]))
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic int a3_at(input int age);
        foreach (q[i])
            if (now - q[i].te == age)
                return q[i].a3;
        return 0;
    endfunction

    function automatic int tnew_at(input int age);
        foreach (q[i])
            if (now - q[i].te == age)
                return rem(q[i]);
        return 0;
    endfunction

    task automatic step(input int a3, input int tnew, input int rs, input int rsu,
                        input int rt, input int rtu, input int kind, input int use_md,
                        input bit rst, output bit st);
        bit busy_x, stall_x;
        d_a3 = 5'(a3); d_tnew = 2'(tnew); d_rs = 5'(rs); rs_tuse = 2'(rsu);
        d_rt = 5'(rt); rt_tuse = 2'(rtu); d_md_kind = 2'(kind); d_md_use = use_md != 0;
        reset = rst;
        #1;
        busy_x  = MD_EN && now < md_free;
        stall_x = hz(rs, rsu) || hz(rt, rtu) || (use_md != 0 && busy_x);
        if (chk_en) begin
            check("stall", int'(stall), int'(stall_x));
            check("md_busy", int'(md_busy), int'(busy_x));
            check("e_a3", int'(e_a3), a3_at(0));
            check("e_tnew", int'(e_tnew), tnew_at(0));
            check("m_a3", int'(m_a3), a3_at(1));
            check("m_tnew", int'(m_tnew), tnew_at(1));
            check("w_a3", int'(w_a3), a3_at(2));
        end
        st = stall;
        @(posedge clk);
        if (rst) begin
            q.delete();
            md_free = 0;
        end else if (!stall_x) begin
            q.push_back('{a3, tnew, now + 1});
            if (MD_EN && (kind == 1 || kind == 2))
                md_free = now + 2 + (kind == 2 ? DIV_N : MULT_N);
        end
        now++;
        while (q.size() > 0 && now - q[0].te > 2)
            void'(q.pop_front());
        @(negedge clk);
    endtask

    task automatic nop(input int n);
        bit st;
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 3, 0, 3, 0, 0, 1'b0, st);
    endtask

    // Holds the instruction in D until the DUT releases it; returns the stall cycles seen.
    task automatic issue(input int a3, input int tnew, input int rs, input int rsu,
                         input int rt, input int rtu, input int kind, input int use_md,
                         output int stalls);
        bit st;
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            step(a3, tnew, rs, rsu, rt, rtu, kind, use_md, 1'b0, st);
            if (!st)
                return;
            stalls++;
        end
        check("stall_bound", int'(st), 0);
    endtask

    initial begin
        int n;
        bit st;
        @(negedge clk);
        step(0, 0, 0, 3, 0, 3, 0, 0, 1'b1, st);
        chk_en = 1'b1;
        step(0, 0, 0, 3, 0, 3, 0, 0, 1'b1, st);
        check("rst_stall", int'(stall), 0);
        check("rst_md_busy", int'(md_busy), 0);
        check("rst_stage_a3", int'(e_a3 | m_a3 | w_a3), 0);

        issue(8, 2, 0, 3, 0, 3, 0, 0, n);
        issue(10, 1, 8, 1, 0, 3, 0, 0, n);
        check("lw_addu_stalls", n, 1);
        nop(3);
        issue(8, 2, 0, 3, 0, 3, 0, 0, n);
        issue(0, 3, 0, 3, 8, 0, 0, 0, n);
        check("lw_beq_stalls", n, 2);
        check("lw_beq_w_a3", int'(w_a3), 0);
        nop(3);
        issue(0, 1, 0, 3, 0, 3, 0, 0, n);
        issue(0, 3, 0, 0, 0, 3, 0, 0, n);
        check("r0_stalls", n, 0);
        nop(3);
        issue(0, 0, 0, 3, 0, 3, 1, 1, n);
        issue(12, 2, 0, 3, 0, 3, 0, 1, n);
        check("mult_mflo_stalls", n, MD_EN ? 6 : 0);
        nop(3);
        issue(9, 1, 0, 3, 0, 3, 0, 0, n);
        issue(0, 0, 0, 3, 9, 2, 0, 0, n);
        check("addu_sw_stalls", n, 0);
        nop(3);
        issue(9, 2, 0, 3, 0, 3, 0, 0, n);
        issue(0, 0, 0, 3, 9, 2, 0, 0, n);
        check("lw_sw_stalls", n, 0);
        nop(3);
        issue(0, 0, 0, 3, 0, 3, 2, 1, n);
        nop(4);
        check("div_busy", int'(md_busy), int'(MD_EN));
        step(0, 0, 0, 3, 0, 3, 0, 0, 1'b1, st);
        check("div_rst_md_busy", int'(md_busy), 0);
        check("div_rst_stage_a3", int'(e_a3 | m_a3 | w_a3), 0);

        for (int i = 0; i < 3000; i++) begin
            int kind;
            kind = $urandom_range(0, 9) == 0 ? int'($urandom_range(1, 3)) : 0;
            step($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 kind, $urandom_range(0, 3) == 0 ? 1 : 0, $urandom_range(0, 49) == 0, st);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
